ram8: RTL and testbench



---
 rtl/ram8.sv | 77 +++++++
 tb/tb_ram8.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ram8.sv
// ----------------------------------------------------------------------------
// ram8 -- 8-word x WIDTH-bit Hack RAM8.
//
// Eight word registers, each with its own write enable. The enables come
// from a dmux8way-style decode of (load, address). The read word comes from
// a mux8way-style select on address. This is the leaf of the
// RAM64/RAM512/... data-memory hierarchy.
//
// Parameters
//   WIDTH    data word width in bits (default 16)
//   RST_VAL  value loaded into every word on reset (WIDTH bits, default 0)
//
// Ports
//   clk      in   1      single clock; all writes on the rising edge
//   reset    in   1      asynchronous, active-high; sets every word to RST_VAL
//   in       in   WIDTH  write data
//   load     in   1      write enable for the addressed word
//   address  in   3      word select 0..7
//   out      out  WIDTH  read data of word[address] (combinational)
//
// Build option
//   RAM8_WRITE_THROUGH_EN  when defined, out follows `in` while load=1, so
//                          the value being written shows in the same cycle.
//                          Storage behaves the same in both builds.
// ----------------------------------------------------------------------------
module ram8 #(
  parameter int unsigned           WIDTH   = 16,
  parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic [2:0]       address,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] word [8];
  logic [7:0]       ld;
  logic [WIDTH-1:0] rd;

  // dmux8way: ld[0] selects address 000 and ld[7] selects address 111.
  // All enables stay low when load=0.
  always_comb begin
    ld = '0;
    if (load) ld[address] = 1'b1;
  end

  // Reset wins over any write. A write that is pending while reset is high
  // is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 8; i++) word[3'(i)] <= RST_VAL;
    end else begin
      for (int unsigned i = 0; i < 8; i++)
        if (ld[3'(i)]) word[3'(i)] <= in;
    end
  end

  // mux8way16: combinational read with zero cycles of latency.
  always_comb begin
    rd = word[address];
  end

`ifdef RAM8_WRITE_THROUGH_EN
  // The read and write address are the same, so a write always targets the
  // word on out.
  always_comb begin
    out = load ? in : rd;
  end
`else
  always_comb begin
    out = rd;
  end
`endif

endmodule

// File: tb/tb_ram8.sv
// ----------------------------------------------------------------------------
// tb_ram8 -- self-checking directed testbench for ram8.
// Inputs change on the falling clock edge. Outputs are sampled #1 after the
// rising edge, or between edges for combinational reads.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ram8;

  logic        clk = 1'b0;
  logic        run = 1'b0;
  logic        reset;
  logic [15:0] din;
  logic        load;
  logic [2:0]  address;
  logic [15:0] dout;

  int total = 0;
  int bad   = 0;

  ram8 #(.WIDTH(16), .RST_VAL(16'h0000)) dut (
    .clk(clk), .reset(reset), .in(din), .load(load),
    .address(address), .out(dout)
  );

  always #5 if (run) clk = ~clk;

  initial begin
    #20000;
    $display("FAIL watchdog: actual=timeout required=finish");
    bad = bad + 1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic test_reset;
    reset = 1'b1; load = 1'b0; din = 16'h0000; address = 3'd0;
    #1;
    for (int i = 0; i < 8; i++) begin
      address = 3'(i); #1;
      total = total + 1;
      if (dout !== 16'h0000) begin
        bad = bad + 1;
        $display("FAIL reset_read[%0d]: actual=%h required=0000", i, dout);
      end
    end
    run = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_write_all;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      load = 1'b1; address = 3'(i); din = 16'h1000 + 16'(i);
      @(posedge clk);
    end
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      address = 3'(i); #1;
      total = total + 1;
      if (dout !== 16'h1000 + 16'(i)) begin
        bad = bad + 1;
        $display("FAIL write_all[%0d]: actual=%h required=%h", i, dout, 16'h1000 + 16'(i));
      end
    end
  endtask

  task automatic test_isolation;
    @(negedge clk);
    load = 1'b1; address = 3'd3; din = 16'hBEEF;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0; din = 16'hFFFF;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      total = total + 1;
      if (dout !== 16'hBEEF) begin
        bad = bad + 1;
        $display("FAIL isolation_hold[%0d]: actual=%h required=BEEF", k, dout);
      end
    end
    @(negedge clk);
    address = 3'd4; #1;
    total = total + 1;
    if (dout !== 16'h1004) begin
      bad = bad + 1;
      $display("FAIL isolation_word4: actual=%h required=1004", dout);
    end
    // A glitch on load between edges must not write.
    load = 1'b1; din = 16'h0BAD; #1; load = 1'b0; #1;
    @(posedge clk); #1;
    total = total + 1;
    if (dout !== 16'h1004) begin
      bad = bad + 1;
      $display("FAIL glitch_word4: actual=%h required=1004", dout);
    end
  endtask

  task automatic test_write_timing;
    @(negedge clk);
    address = 3'd5; din = 16'hA5A5; load = 1'b1; #1;
    total = total + 1;
`ifdef RAM8_WRITE_THROUGH_EN
    if (dout !== 16'hA5A5) begin
      bad = bad + 1;
      $display("FAIL timing_before: actual=%h required=A5A5", dout);
    end
`else
    if (dout !== 16'h1005) begin
      bad = bad + 1;
      $display("FAIL timing_before: actual=%h required=1005", dout);
    end
`endif
    @(posedge clk); #1;
    total = total + 1;
    if (dout !== 16'hA5A5) begin
      bad = bad + 1;
      $display("FAIL timing_after: actual=%h required=A5A5", dout);
    end
    // Back-to-back writes to the same word: the last edge wins.
    @(negedge clk); din = 16'h1111;
    @(negedge clk); din = 16'h2222;
    @(negedge clk); load = 1'b0; #1;
    total = total + 1;
    if (dout !== 16'h2222) begin
      bad = bad + 1;
      $display("FAIL back_to_back: actual=%h required=2222", dout);
    end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    address = 3'd2; din = 16'h1234; load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0; #1;
    total = total + 1;
    if (dout !== 16'h1234) begin
      bad = bad + 1;
      $display("FAIL pre_reset_word2: actual=%h required=1234", dout);
    end
    load = 1'b1; din = 16'h5678; #1;
    reset = 1'b1; #1;
    total = total + 1;
    if (dout !== 16'h0000) begin
      bad = bad + 1;
      $display("FAIL reset_immediate: actual=%h required=0000", dout);
    end
    @(posedge clk); #1;
    total = total + 1;
    if (dout !== 16'h0000) begin
      bad = bad + 1;
      $display("FAIL reset_blocks_write: actual=%h required=0000", dout);
    end
  endtask

  task automatic test_release_overwrite;
    @(negedge clk);
    reset = 1'b0; load = 1'b1; address = 3'd7; din = 16'h7FFF;
    @(posedge clk); #1;
    total = total + 1;
    if (dout !== 16'h7FFF) begin
      bad = bad + 1;
      $display("FAIL release_word7: actual=%h required=7FFF", dout);
    end
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < 7; i++) begin
      address = 3'(i); #1;
      total = total + 1;
      if (dout !== 16'h0000) begin
        bad = bad + 1;
        $display("FAIL release_other[%0d]: actual=%h required=0000", i, dout);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_all();
    test_isolation();
    test_write_timing();
    test_async_reset();
    test_release_overwrite();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
